// File: rtl/uart_pkg.sv
// Shared UART definitions: TX FSM states, parity constants
// and the parity helper used by both TX and RX.
package uart_pkg;

  localparam int DATA_W = 8;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  function automatic logic parity_calc(
    input logic [DATA_W-1:0] data,
    input logic typ
  );
    return (^data) ^ typ;
  endfunction

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Prescale tick counter: bit_done pulses on the last cycle of
// every bit period; clear restarts the count for a new frame.
module uart_tx_bit_timer #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] prescale_l,
  output logic                  bit_done
);

  logic [PRESCALE_W-1:0] cnt_q, cnt_d;

  assign bit_done = run && (cnt_q == prescale_l - PRESCALE_W'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear || bit_done) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: start, 8 data LSB-first, optional parity, stop.
// Define UART_TX_STOP2_EN for two stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DATA_W);
`ifdef UART_TX_STOP2_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif

  tx_state_e state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic par_en_q, par_en_d;
  logic par_typ_q, par_typ_d;
  logic [PRESCALE_W-1:0] pscl_q, pscl_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic tx_q, tx_d;
  logic busy_q, busy_d;
  logic accept, run, bit_done;

  assign accept = (state_q == IDLE) && Data_Valid;
  assign run = (state_q != IDLE);

  uart_tx_bit_timer #(
    .PRESCALE_W(PRESCALE_W)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .run       (run),
    .prescale_l(pscl_q),
    .bit_done  (bit_done)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    pscl_d    = pscl_q;
    idx_d     = idx_q;
    unique case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_typ_d = PAR_TYP;
          pscl_d    = (prescale == '0) ? PRESCALE_W'(1) : prescale;
          idx_d     = '0;
          state_d   = START;
        end
      end
      START: begin
        if (bit_done) begin
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_W'(DATA_W - 1)) begin
            idx_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d = STOP;
        end
      end
      STOP: begin
        // idx counts stop bits already sent
        if (bit_done) begin
          if (idx_q == IDX_W'(STOP_BITS - 1)) begin
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode the next state so they register glitch-free
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_q[idx_d];
      PARITY:  tx_d = parity_calc(data_q, par_typ_q);
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      pscl_q    <= '0;
      idx_q     <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      pscl_q    <= pscl_d;
      idx_q     <= idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign busy = busy_q;

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit-side stage that produces the serial RX_IN stream consumed by the UART receiver.
- Accepts an 8-bit parallel word with a valid strobe and serializes it as start bit, 8 data bits LSB-first, optional parity bit, then stop bit.
- Each bit is held for `prescale` clock cycles, so the RX oversampling setting and the TX bit period come from one shared value.
- Sits between the system-side data source and the serial line.

Parameters:
- DATA_W, 8, width of the parallel data word.
- PRESCALE_W, 6, width of the prescale input.

Ports:
- clk  in  1  single system clock.
- rst  in  1  synchronous, active-high reset.
- P_DATA  in  DATA_W  parallel word to transmit.
- Data_Valid  in  1  request strobe, sampled only while busy=0.
- PAR_EN  in  1  1 = parity bit inserted.
- PAR_TYP  in  1  0 = even parity, 1 = odd parity.
- prescale  in  PRESCALE_W  clocks per bit; 0 is treated as 1.
- TX_OUT  out  1  serial line, idles high.
- busy  out  1  frame in progress.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: TX_OUT=1, busy=0, FSM=IDLE, all counters 0.
  - Reset asserted mid-frame aborts the frame at the next edge.
  - No partial-frame recovery.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=1, busy=0.
  - If Data_Valid=1, latch P_DATA, PAR_EN, PAR_TYP and prescale (0 replaced by 1). Go to START.
  - Latched values stay frozen for the whole frame.
- Latency: TX_OUT drops to 0 and busy rises on the first edge after the acceptance cycle.
- Bit timing:
  - A tick counter counts 0..prescale_l-1.
  - The bit advances when the counter reaches prescale_l-1; the counter then wraps to 0.
  - Every bit is exactly prescale_l cycles.
- START: TX_OUT=0 → DATA.
- DATA: TX_OUT=data_l[bit_idx]; bit_idx runs 0..7. After bit 7 → PARITY if PAR_EN latched, else STOP.
- PARITY: TX_OUT = ^data_l XOR PAR_TYP_l → STOP.
- STOP: TX_OUT=1. At the end of the stop bit → IDLE, with busy=0 on that same edge.
- Back-to-back: Data_Valid high on the first busy=0 cycle is accepted. Minimum gap between frames is 1 idle cycle.
- Data_Valid while busy=1 is ignored. It is not queued and does not corrupt the frame.
- Changes on P_DATA/PAR_EN/PAR_TYP/prescale mid-frame have no effect.
- Frame length (cycles from first START cycle to end of STOP): (10+PAR_EN)*prescale_l.
- TX_OUT is driven from a register (glitch-free).

Optional Feature:
- Macro: UART_TX_STOP2_EN.
- Defined: STOP state lasts 2*prescale_l cycles (two stop bits). Frame length becomes (11+PAR_EN)*prescale_l.
- Undefined: a single stop bit, as described above.

Decomposition:
- Shared package uart_pkg holds:
  - enum tx_state_e {IDLE, START, DATA, PARITY, STOP}.
  - Constants DATA_W=8, PAR_EVEN=0, PAR_ODD=1.
  - Function parity_calc(data, typ); the receiver's parity checker uses the same function.
- One sub-module: uart_tx_bit_timer. It is the prescale tick counter producing bit_done, with clear-on-start.
- The FSM, shift/index logic and output mux live in the top module.

Test Plan:
- Reset mid-frame:
  - Stimulus: P_DATA=8'hA5, PAR_EN=0, prescale=8; assert rst after 30 cycles, held 1 cycle.
  - Required: TX_OUT=1 and busy=0 on the next edge; a new 8'h3C frame is then sent cleanly.
- Even parity:
  - Stimulus: P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, prescale=8.
  - Required: TX_OUT sequence 0,1,0,1,0,0,1,0,1, parity 0, stop 1; each level held 8 cycles; busy high for exactly 88 cycles.
- Odd parity, all ones:
  - Stimulus: P_DATA=8'hFF, PAR_EN=1, PAR_TYP=1, prescale=16.
  - Required: parity bit = 1; frame length 176 cycles.
- Ignored request while busy:
  - Stimulus: Data_Valid pulsed with 8'h00 while busy during an 8'h0F frame (PAR_EN=0, prescale=8).
  - Required: only the 8'h0F frame appears; busy low after 80 cycles.
- Back-to-back frames:
  - Stimulus: Data_Valid held high with 8'h55 then 8'hAA, prescale=1.
  - Required: two 10-cycle frames separated by exactly 1 idle-high cycle.
- Loopback with the receiver:
  - Stimulus: TX_OUT tied to the receiver's RX_IN, prescale=8, random 200 words with random PAR_EN/PAR_TYP.
  - Required: every receiver data_valid shows P_DATA equal to the sent word; no parity errors.
